muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative integer multiply/divide unit implementing the RISC-V M-extension, with optional RV64 word (*W) mode.
It sits beside the 64-bit ALU in the execute stage and is selected when the opcode is OP/OP-32 with funct7=0000001.
Operands are captured on a start pulse. The result is produced after a fixed, mode-dependent number of cycles, with a busy/done handshake so control can stall the PC.
Parametrised in XLEN so the same block serves RV32 and RV64 cores.

Parameters:
XLEN, 64, operand/result width; must be 32 or 64.
WORD_EN, 1, enables the word input (RV64 *W ops); legal only when XLEN=64, otherwise word is ignored.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
word  input  1  1 = *W op: operate on [31:0], sign-extend 32-bit result to XLEN
operand_a  input  XLEN  rs1 value (multiplicand / dividend)
operand_b  input  XLEN  rs2 value (multiplier / divisor)
busy  output  1  high from the edge after start is accepted until done
done  output  1  single-cycle pulse, result valid
result  output  XLEN  registered result; held until the next accepted start

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0; iteration counter=0. Reset takes priority over every other event, including mid-operation; any in-flight op is discarded and no done is produced.
- Effective width N = 32 if (word & WORD_EN & XLEN==64), else XLEN.
- States:
  - IDLE: start=1 latches funct3, word, operands, sign flags and N; next state CALC (or FIN on a special case); busy=1.
  - CALC: one iteration per edge, counter increments; after N iterations, next state FIN.
  - FIN: sign correction and result select, registered into result; next state DONE.
  - DONE: done=1, busy=0 for exactly one cycle, then IDLE. start in DONE is ignored.
- Latency (normal ops): with the start-sampling edge as E0, done is high in the cycle after edge E(N+1). For XLEN=64 that is 65 edges (full ops) or 33 edges (word ops).
- start while busy=1 or in DONE: ignored; no queueing.
- Multiply: radix-2 shift-add on |a|,|b| into a 2N-bit product. Signs are applied per funct3:
  - MUL / MULW: low N bits.
  - MULH / MULHSU / MULHU: high N bits.
  - MULHSU: a signed, b unsigned.
- Divide: restoring, one quotient bit per cycle on magnitudes.
  - Quotient sign = sa^sb.
  - Remainder sign = sign of dividend.
  - Truncation toward zero.
- Special cases, detected in IDLE; these skip CALC, go IDLE->FIN->DONE, and done is high after E1:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow (dividend = -2^(N-1), divisor = -1): DIV = -2^(N-1); REM = 0.
- Word mode: the result's bit 31 is replicated into [XLEN-1:32]. For MULH* with word=1 (illegal encoding), output is the low-32 MULW result.
- result changes only in FIN; it is stable at all other times.

Test Plan:
- MUL: a=7, b=0xFFFF_FFFF_FFFF_FFF9 (-7) -> result 0xFFFF_FFFF_FFFF_FFCF (-49); done exactly 65 edges after the start edge; busy high throughout the 64 iteration cycles.
- MULHU: a = b = 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands -> 0x0. MULHSU: a=-1, b=2 -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV: a=-7, b=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3). REM on the same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1). DIVU: a=100, b=7 -> 14.
- Special cases:
  - DIVU 5/0 -> 0xFFFF_FFFF_FFFF_FFFF.
  - REM 5/0 -> 5.
  - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
  - REM on the same operands -> 0.
  - Each completes with done after E1.
- Word mode: MULW with a=0x0000_0000_7FFF_FFFF, b=2 -> 0xFFFF_FFFF_FFFF_FFFE, done after 33 edges. DIVW with a=0x1_0000_0010, b=0xFFFF_FFFF_FFFF_FFFE -> 0xFFFF_FFFF_FFFF_FFF8.
- Handshake and reset:
  - start pulsed again mid-operation: ignored, and the first result is correct.
  - reset asserted at iteration 20: busy=0, done=0, result=0 on the next edge; no done follows.
  - A new start after reset completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit.
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           one-cycle request, sampled only while idle
//   funct3          M-extension operation select
//   word            RV64 *W op (32-bit operate, sign-extended result)
//   operand_a/b     rs1 / rs2 values
//   busy            high from the edge that accepts start until done
//   done            one-cycle result-valid pulse
//   result          registered result, held until the next accepted start
module muldiv_unit #(
  parameter int unsigned XLEN    = 64,
  parameter bit          WORD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic            word,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic            word_q, word_d;
  logic            neg_a_q, neg_a_d;
  logic            neg_b_q, neg_b_d;
  logic            special_q, special_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   mc_q, mc_d;     // multiplicand (shifts left) / divisor magnitude
  logic [XLEN-1:0] ml_q, ml_d;     // multiplier (shifts right) / dividend->quotient (shifts left)
  logic [PW-1:0]   acc_q, acc_d;   // product / partial remainder / special-case result
  logic [XLEN-1:0] result_q, result_d;

  // Operand decode, only meaningful in idle
  logic            word_eff;
  logic [XLEN-1:0] mask_n;
  logic [XLEN-1:0] a_n, b_n;
  logic            a_top, b_top;
  logic            sgn_a, sgn_b;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] min_n;
  logic            is_div;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    word_eff = WORD_EN && (XLEN == 64) && word;
    mask_n   = '1;
    if (word_eff) begin
      mask_n = mask_n >> (XLEN - 32);
    end
    a_n   = operand_a & mask_n;
    b_n   = operand_b & mask_n;
    a_top = word_eff ? operand_a[31] : operand_a[XLEN-1];
    b_top = word_eff ? operand_b[31] : operand_b[XLEN-1];

    is_div = funct3[2];
    if (is_div) begin
      sgn_a = ~funct3[0];
      sgn_b = ~funct3[0];
    end else begin
      sgn_a = (funct3[1:0] != 2'b11);
      sgn_b = ~funct3[1];
    end
    neg_a = sgn_a & a_top;
    neg_b = sgn_b & b_top;
    mag_a = neg_a ? ((~operand_a + XLEN'(1)) & mask_n) : a_n;
    mag_b = neg_b ? ((~operand_b + XLEN'(1)) & mask_n) : b_n;

    min_n    = mask_n ^ (mask_n >> 1);
    div_zero = is_div && (b_n == '0);
    div_ovf  = is_div && !funct3[0] && (a_n == min_n) && (b_n == mask_n);

    spec_res = '0;
    if (div_zero) begin
      spec_res = funct3[1] ? a_n : mask_n;
    end else if (div_ovf) begin
      spec_res = funct3[1] ? '0 : min_n;
    end
  end

  // Datapath terms for the iterate and finish states
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] diff;
  logic [PW-1:0]   prod_s;
  logic [XLEN-1:0] rem_mag;
  logic [XLEN-1:0] quo_s, rem_s;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] fin_res;
  logic [CW-1:0]   n_last;
  logic            mul_hi;

  always_comb begin
    rem_sh  = {acc_q[XLEN-1:0], ml_q[XLEN-1]};
    diff    = {1'b0, rem_sh} - {2'b00, mc_q[XLEN-1:0]};
    prod_s  = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    rem_mag = acc_q[XLEN-1:0];
    quo_s   = (neg_a_q ^ neg_b_q) ? -ml_q : ml_q;
    rem_s   = neg_a_q ? -rem_mag : rem_mag;
    n_last  = word_q ? CW'(31) : CW'(XLEN - 1);
    // High-half multiplies in word mode are illegal; they fall back to the low half.
    mul_hi  = (f3_q[1:0] != 2'b00) && !word_q;

    if (special_q) begin
      raw = rem_mag;
    end else if (f3_q[2]) begin
      raw = f3_q[1] ? rem_s : quo_s;
    end else begin
      raw = mul_hi ? prod_s[PW-1:XLEN] : prod_s[XLEN-1:0];
    end

    fin_res = raw;
    if (word_q) begin
      for (int unsigned i = 32; i < XLEN; i++) begin
        fin_res[i] = raw[31];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    word_d    = word_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    special_d = special_q;
    cnt_d     = cnt_q;
    mc_d      = mc_q;
    ml_d      = ml_q;
    acc_d     = acc_q;
    result_d  = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d      = funct3;
          word_d    = word_eff;
          neg_a_d   = neg_a;
          neg_b_d   = neg_b;
          cnt_d     = '0;
          special_d = div_zero || div_ovf;
          if (is_div) begin
            mc_d  = PW'(mag_b);
            // Align the dividend to the top so both widths shift out of bit XLEN-1.
            ml_d  = word_eff ? (mag_a << (XLEN - 32)) : mag_a;
            acc_d = '0;
          end else begin
            mc_d  = PW'(mag_a);
            ml_d  = mag_b;
            acc_d = '0;
          end
          if (div_zero || div_ovf) begin
            acc_d   = PW'(spec_res);
            state_d = S_FIN;
          end else begin
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (f3_q[2]) begin
          // Restoring step: keep the difference only when it did not borrow.
          if (!diff[XLEN+1]) begin
            acc_d = PW'(diff[XLEN:0]);
            ml_d  = {ml_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = PW'(rem_sh);
            ml_d  = {ml_q[XLEN-2:0], 1'b0};
          end
        end else begin
          if (ml_q[0]) begin
            acc_d = acc_q + mc_q;
          end
          mc_d = mc_q << 1;
          ml_d = ml_q >> 1;
        end
        if (cnt_q == n_last) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        result_d = fin_res;
        state_d  = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      f3_q      <= '0;
      word_q    <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      special_q <= 1'b0;
      cnt_q     <= '0;
      mc_q      <= '0;
      ml_q      <= '0;
      acc_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      word_q    <= word_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      special_q <= special_d;
      cnt_q     <= cnt_d;
      mc_q      <= mc_d;
      ml_q      <= ml_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q == S_CALC) || (state_q == S_FIN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic        word;
  logic [63:0] operand_a;
  logic [63:0] operand_b;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int total;
  int bad;

  typedef struct {
    string       tag;
    logic [63:0] res;
  } sb_t;

  sb_t sb_q[$];
  sb_t mon_e;

  muldiv_unit #(.XLEN(64), .WORD_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .funct3    (funct3),
    .word      (word),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pending request
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq(mon_e.tag, result, mon_e.res);
      end
    end
  end

  function automatic logic [63:0] ref_model(input logic [2:0] f3, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, p;
    logic signed [63:0]  sa64, sb64;
    logic signed [31:0]  sa32, sb32;
    logic [31:0]         a32, b32, r32;
    logic [63:0]         r;
    sa64 = a;
    sb64 = b;
    a32  = a[31:0];
    b32  = b[31:0];
    sa32 = a32;
    sb32 = b32;
    r32  = '0;
    r    = '0;
    if (w) begin
      if (!f3[2]) begin
        r32 = a32 * b32;
      end else if (b32 == 32'd0) begin
        r32 = f3[1] ? a32 : 32'hFFFF_FFFF;
      end else if (!f3[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        r32 = f3[1] ? 32'd0 : a32;
      end else begin
        case (f3[1:0])
          2'b00:   r32 = sa32 / sb32;
          2'b01:   r32 = a32 / b32;
          2'b10:   r32 = sa32 % sb32;
          default: r32 = a32 % b32;
        endcase
      end
      r = {{32{r32[31]}}, r32};
    end else begin
      if (!f3[2]) begin
        pa = (f3[1:0] == 2'b11) ? {64'd0, a} : {{64{a[63]}}, a};
        pb = (f3[1]) ? {64'd0, b} : {{64{b[63]}}, b};
        p  = pa * pb;
        r  = (f3[1:0] == 2'b00) ? p[63:0] : p[127:64];
      end else if (b == 64'd0) begin
        r = f3[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (!f3[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        r = f3[1] ? 64'd0 : a;
      end else begin
        case (f3[1:0])
          2'b00:   r = sa64 / sb64;
          2'b01:   r = a / b;
          2'b10:   r = sa64 % sb64;
          default: r = a % b;
        endcase
      end
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    if (f3[2]) begin
      if (w) begin
        if (b[31:0] == 32'd0) return 1;
        if (!f3[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      end else begin
        if (b == 64'd0) return 1;
        if (!f3[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
      end
    end
    return w ? 33 : 65;
  endfunction

  task automatic do_op(input string tag, input logic [2:0] f3, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat, input int poke);
    int  edges;
    int  busy_bad;
    sb_t e;
    @(negedge clk);
    start     = 1'b1;
    funct3    = f3;
    word      = w;
    operand_a = a;
    operand_b = b;
    e.tag     = tag;
    e.res     = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start     = 1'b0;
    funct3    = f3 ^ 3'b101;
    word      = ~w;
    operand_a = {$urandom, $urandom};
    operand_b = {$urandom, $urandom};
    edges     = 0;
    busy_bad  = 0;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      start = 1'b0;
      if (done) break;
      if (!busy) busy_bad++;
      if (edges == poke) start = 1'b1;
    end
    check_eq({tag, "_latency"}, 64'(edges), 64'(lat));
    check_eq({tag, "_busy_held"}, 64'(busy_bad), 64'd0);
    check_eq({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    // start presented while done is high must not be accepted
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    check_eq({tag, "_start_in_done"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [2:0]  rf3;
    logic        rw;
    logic [63:0] ra, rb;
    int          n;
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    start     = 1'b0;
    funct3    = 3'b000;
    word      = 1'b0;
    operand_a = '0;
    operand_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", {63'd0, busy}, 64'd0);
    check_eq("reset_done", {63'd0, done}, 64'd0);
    check_eq("reset_result", result, 64'd0);
    reset = 1'b0;

    do_op("mul",      3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFCF, 65, -1);
    do_op("mulhu",    3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65, -1);
    do_op("mulh",     3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65, -1);
    do_op("mulhsu",   3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, -1);
    do_op("div",      3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, -1);
    do_op("rem",      3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, -1);
    do_op("divu",     3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65, -1);
    do_op("divu_by0", 3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, -1);
    do_op("rem_by0",  3'b110, 1'b0, 64'd5, 64'd0, 64'd5, 1, -1);
    do_op("div_ovf",  3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, -1);
    do_op("rem_ovf",  3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, -1);
    do_op("mulw",     3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, -1);
    do_op("divw",     3'b100, 1'b1, 64'h0000_0001_0000_0010, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF8, 33, -1);
    do_op("divw_ovf", 3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, -1);
    do_op("mulhw_ill",3'b001, 1'b1, 64'h0000_0000_0001_0000, 64'h0000_0000_0001_0000, 64'd0, 33, -1);
    do_op("mul_poke", 3'b000, 1'b0, 64'd3, 64'd5, 64'd15, 65, 10);

    // Reset in the middle of an operation discards it
    @(negedge clk);
    start     = 1'b1;
    funct3    = 3'b000;
    word      = 1'b0;
    operand_a = 64'd11;
    operand_b = 64'd13;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("rst_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_result", result, 64'd0);
    reset = 1'b0;
    n = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    check_eq("rst_no_done", 64'(n), 64'd0);

    do_op("after_rst", 3'b101, 1'b0, 64'd1000, 64'd9, 64'd111, 65, -1);

    for (int i = 0; i < 12; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      rw  = 1'($urandom_range(0, 1));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      if (i % 3 == 0) rb = 64'($urandom_range(1, 50));
      if (i % 4 == 1) ra = 64'($urandom_range(0, 1000));
      if (i % 5 == 2) rb = ~rb + 64'd1;
      do_op("rand", rf3, rw, ra, rb, ref_model(rf3, rw, ra, rb), exp_lat(rf3, rw, ra, rb), -1);
    end

    repeat (5) @(posedge clk);
    #1;
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
